// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: NMBOX mailboxes, lowest-ID arbitration, start/busy
// handshake with the transmitter core, completion and start-timeout reporting.
module can_tx_scheduler #(
   parameter int NMBOX    = 4,
   parameter int START_TO = 16
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic                     ld_valid,
   input  logic [$clog2(NMBOX)-1:0] ld_idx,
   input  logic [28:0]              ld_id,
   input  logic [63:0]              ld_data,
   input  logic [31:0]              ld_cmd,
   input  logic [NMBOX-1:0]         abort,
   input  logic                     busy,
   output logic                     startXmit,
   output logic [63:0]              xmitdata,
   output logic [7:0]               quantaDiv,
   output logic [5:0]               propQuanta,
   output logic [5:0]               seg1Quanta,
   output logic [3:0]               datalen,
   output logic                     format,
   output logic [1:0]               frameType,
   output logic [28:0]              id,
   output logic [NMBOX-1:0]         pending,
   output logic                     done,
   output logic                     to_err,
   output logic [$clog2(NMBOX)-1:0] cur_idx,
   output logic                     ld_err,
   output logic                     sched_busy
);

   localparam int IW = $clog2(NMBOX);
   localparam int CW = $clog2(START_TO + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t           r_state;
   logic [28:0]      r_mb_id   [NMBOX];
   logic [63:0]      r_mb_data [NMBOX];
   logic [31:0]      r_mb_cmd  [NMBOX];
   logic [CW-1:0]    r_cnt;

   logic [CW-1:0]    w_cnt_inc;
   logic [IW-1:0]    w_win_idx;
   logic [28:0]      w_win_id;
   logic             w_win_found;
   logic [31:0]      w_win_cmd;
   logic [IW-1:0]    w_lock_idx;
   logic             w_lock_act;
   logic             w_ld_ok;
   logic [NMBOX-1:0] w_lock_oh;
   logic [NMBOX-1:0] w_ld_oh;
   logic [NMBOX-1:0] w_cur_oh;
   logic [NMBOX-1:0] w_pend_base;

   // Arbitration: pending mailbox with the smallest ID, lowest index on a tie
   always_comb begin
      w_win_idx   = '0;
      w_win_id    = '1;
      w_win_found = 1'b0;
      for (int unsigned i = 0; i < NMBOX; i++) begin
         if (pending[i] && (!w_win_found || (r_mb_id[i] < w_win_id))) begin
            w_win_found = 1'b1;
            w_win_id    = r_mb_id[i];
            w_win_idx   = IW'(i);
         end
      end
   end

   assign w_win_cmd  = r_mb_cmd[w_win_idx];

   // In SELECT cur_idx still names the previous frame, so the mailbox being
   // copied out this cycle (the arbitration winner) is the one locked.
   assign w_lock_act = (r_state != S_IDLE);
   assign w_lock_idx = (r_state == S_SELECT) ? w_win_idx : cur_idx;
   assign w_lock_oh  = w_lock_act ? (NMBOX'(1) << w_lock_idx) : '0;

   assign w_ld_ok    = ld_valid && (32'(ld_idx) < NMBOX) &&
                       !(w_lock_act && (ld_idx == w_lock_idx));
   assign w_ld_oh    = w_ld_ok ? (NMBOX'(1) << ld_idx) : '0;

   // Abort drops unlocked mailboxes; a same-cycle load overrides the abort
   assign w_pend_base = (pending & ~(abort & ~w_lock_oh)) | w_ld_oh;
   assign w_cur_oh    = NMBOX'(1) << cur_idx;
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign sched_busy  = w_lock_act;

   // Mailbox storage, written by accepted loads only
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int unsigned i = 0; i < NMBOX; i++) begin
            r_mb_id[i]   <= '0;
            r_mb_data[i] <= '0;
            r_mb_cmd[i]  <= '0;
         end
      end else if (w_ld_ok) begin
         r_mb_id[ld_idx]   <= ld_id;
         r_mb_data[ld_idx] <= ld_data;
         r_mb_cmd[ld_idx]  <= ld_cmd;
      end
   end

   // Scheduler FSM with registered handshake, status and frame-field outputs
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         pending    <= '0;
         startXmit  <= 1'b0;
         done       <= 1'b0;
         to_err     <= 1'b0;
         ld_err     <= 1'b0;
         cur_idx    <= '0;
         xmitdata   <= '0;
         quantaDiv  <= '0;
         propQuanta <= '0;
         seg1Quanta <= '0;
         datalen    <= '0;
         format     <= 1'b0;
         frameType  <= '0;
         id         <= '0;
      end else begin
         pending   <= w_pend_base;
         startXmit <= 1'b0;
         done      <= 1'b0;
         to_err    <= 1'b0;
         ld_err    <= ld_valid && !w_ld_ok;
         case (r_state)
            S_IDLE: begin
               if (|pending) r_state <= S_SELECT;
            end
            S_SELECT: begin
               // everything may have been aborted on the way into SELECT
               if (w_win_found) begin
                  cur_idx    <= w_win_idx;
                  id         <= r_mb_id[w_win_idx];
                  xmitdata   <= r_mb_data[w_win_idx];
                  quantaDiv  <= w_win_cmd[31:24];
                  propQuanta <= w_win_cmd[23:18];
                  seg1Quanta <= w_win_cmd[17:12];
                  datalen    <= w_win_cmd[11:8];
                  format     <= w_win_cmd[7];
                  frameType  <= w_win_cmd[6:5];
                  startXmit  <= 1'b1;
                  r_state    <= S_START;
               end else begin
                  r_state    <= S_IDLE;
               end
            end
            S_START: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (busy) begin
                  r_state <= S_WAIT_DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CW'(START_TO)) begin
                     to_err  <= 1'b1;
                     pending <= w_pend_base & ~w_cur_oh;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (!busy) begin
                  done    <= 1'b1;
                  pending <= w_pend_base & ~w_cur_oh;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler with a simple transmitter busy model.
module tb_can_tx_scheduler;

   localparam int NMBOX    = 4;
   localparam int START_TO = 16;

   logic        HCLK     = 1'b0;
   logic        HRESET   = 1'b1;
   logic        ld_valid = 1'b0;
   logic [1:0]  ld_idx   = '0;
   logic [28:0] ld_id    = '0;
   logic [63:0] ld_data  = '0;
   logic [31:0] ld_cmd   = '0;
   logic [3:0]  abort    = '0;
   logic        busy     = 1'b0;

   logic        startXmit;
   logic [63:0] xmitdata;
   logic [7:0]  quantaDiv;
   logic [5:0]  propQuanta;
   logic [5:0]  seg1Quanta;
   logic [3:0]  datalen;
   logic        format;
   logic [1:0]  frameType;
   logic [28:0] id;
   logic [3:0]  pending;
   logic        done;
   logic        to_err;
   logic [1:0]  cur_idx;
   logic        ld_err;
   logic        sched_busy;

   int total = 0;
   int bad   = 0;
   int ndone = 0;
   int nto   = 0;
   int bcnt  = 0;
   bit bact  = 1'b0;
   bit hold_low = 1'b0;
   int start_log[$];

   can_tx_scheduler #(.NMBOX(NMBOX), .START_TO(START_TO)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .ld_valid(ld_valid), .ld_idx(ld_idx),
      .ld_id(ld_id), .ld_data(ld_data), .ld_cmd(ld_cmd), .abort(abort),
      .busy(busy), .startXmit(startXmit), .xmitdata(xmitdata),
      .quantaDiv(quantaDiv), .propQuanta(propQuanta), .seg1Quanta(seg1Quanta),
      .datalen(datalen), .format(format), .frameType(frameType), .id(id),
      .pending(pending), .done(done), .to_err(to_err), .cur_idx(cur_idx),
      .ld_err(ld_err), .sched_busy(sched_busy)
   );

   always #5 HCLK = ~HCLK;

   // Transmitter model: busy rises 2 cycles after startXmit, falls 20 later
   always @(negedge HCLK) begin
      if (HRESET) begin
         busy = 1'b0;
         bact = 1'b0;
      end else begin
         if (bact) begin
            bcnt++;
            if (bcnt == 2) busy = 1'b1;
            if (bcnt == 22) begin
               busy = 1'b0;
               bact = 1'b0;
            end
         end
         if (startXmit) begin
            start_log.push_back(int'(cur_idx));
            if (!hold_low) begin
               bact = 1'b1;
               bcnt = 0;
            end
         end
         if (done) ndone++;
         if (to_err) nto++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge HCLK);
      #1;
   endtask

   task automatic load(input int idx, input logic [28:0] lid,
                       input logic [63:0] ldat, input logic [31:0] lcmd);
      ld_valid = 1'b1;
      ld_idx   = 2'(idx);
      ld_id    = lid;
      ld_data  = ldat;
      ld_cmd   = lcmd;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int limit, input string tag);
      int c = 0;
      while (start_log.size() < n && c < limit) begin
         tick();
         c++;
      end
      chk(tag, 64'(start_log.size() >= n), 64'd1);
   endtask

   task automatic wait_done(input int n, input int limit, input string tag);
      int c = 0;
      while (ndone < n && c < limit) begin
         tick();
         c++;
      end
      chk(tag, 64'(ndone >= n), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      // reset state
      repeat (3) tick();
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_sbusy", 64'(sched_busy), 64'd0);
      chk("rst_start", 64'(startXmit), 64'd0);
      chk("rst_id", 64'(id), 64'd0);
      HRESET = 1'b0;
      tick();

      // single frame with field decode
      load(0, 29'h123, 64'h1122334455667788, 32'h0A456C80);
      chk("t1_pend_k", 64'(pending), 64'h1);
      chk("t1_idle_k", 64'(sched_busy), 64'd0);
      tick();
      chk("t1_select", 64'(sched_busy), 64'd1);
      chk("t1_nostart", 64'(startXmit), 64'd0);
      tick();
      chk("t1_start", 64'(startXmit), 64'd1);
      chk("t1_cur", 64'(cur_idx), 64'd0);
      chk("t1_id", 64'(id), 64'h123);
      chk("t1_data", xmitdata, 64'h1122334455667788);
      chk("t1_qdiv", 64'(quantaDiv), 64'h0A);
      chk("t1_prop", 64'(propQuanta), 64'h11);
      chk("t1_seg1", 64'(seg1Quanta), 64'h16);
      chk("t1_dlen", 64'(datalen), 64'hC);
      chk("t1_fmt", 64'(format), 64'd1);
      chk("t1_ftype", 64'(frameType), 64'd0);
      tick();
      chk("t1_start_pulse", 64'(startXmit), 64'd0);
      wait_done(1, 60, "t1_done_wait");
      chk("t1_done", 64'(done), 64'd1);
      chk("t1_pend_clr", 64'(pending), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(done), 64'd0);
      repeat (3) tick();
      chk("t1_ndone", 64'(ndone), 64'd1);

      // priority and tie-break: 1/2/3 queued behind a frame on mbox 0
      load(0, 29'h7FF, 64'hAAAA, 32'h01000000);
      wait_starts(2, 10, "t2_first_start");
      load(1, 29'h300, 64'h1, 32'h01000000);
      load(2, 29'h100, 64'h2, 32'h01000000);
      load(3, 29'h100, 64'h3, 32'h01000000);
      wait_done(5, 400, "t2_done_wait");
      chk("t2_order0", 64'(start_log[1]), 64'd0);
      chk("t2_order1", 64'(start_log[2]), 64'd2);
      chk("t2_order2", 64'(start_log[3]), 64'd3);
      chk("t2_order3", 64'(start_log[4]), 64'd1);
      chk("t2_pend", 64'(pending), 64'd0);

      // locked mailbox: load and abort of the in-flight mailbox
      load(0, 29'h055, 64'h55, 32'h02000000);
      wait_starts(6, 10, "t3_start");
      repeat (4) tick();
      load(0, 29'h0AA, 64'hDEAD, 32'h03000000);
      chk("t3_ld_err", 64'(ld_err), 64'd1);
      chk("t3_pend_lock", 64'(pending), 64'h1);
      chk("t3_id_hold", 64'(id), 64'h055);
      abort = 4'b0001;
      tick();
      abort = 4'b0000;
      chk("t3_ld_err_pulse", 64'(ld_err), 64'd0);
      chk("t3_abort_ign", 64'(pending), 64'h1);
      wait_done(6, 60, "t3_done_wait");
      chk("t3_done", 64'(done), 64'd1);
      repeat (5) tick();
      chk("t3_no_resend", 64'(start_log.size()), 64'd6);
      chk("t3_pend", 64'(pending), 64'd0);

      // abort/load collision on a queued mailbox
      load(0, 29'h010, 64'h10, 32'h01000000);
      wait_starts(7, 10, "t4_start");
      repeat (4) tick();
      load(1, 29'h200, 64'h20, 32'h01000000);
      chk("t4_pend_q", 64'(pending), 64'h3);
      abort = 4'b0010;
      load(1, 29'h222, 64'h22, 32'h01000000);
      abort = 4'b0000;
      chk("t4_collide", 64'(pending), 64'h3);
      abort = 4'b0010;
      tick();
      abort = 4'b0000;
      chk("t4_abort", 64'(pending), 64'h1);
      wait_done(7, 60, "t4_done_wait");
      repeat (5) tick();
      chk("t4_no_tx", 64'(start_log.size()), 64'd7);
      chk("t4_idle", 64'(sched_busy), 64'd0);

      // start timeout, then the next pending mailbox goes out
      hold_low = 1'b1;
      load(2, 29'h050, 64'h50, 32'h01000000);
      load(3, 29'h060, 64'h60, 32'h01000000);
      wait_starts(8, 10, "t5_start");
      chk("t5_first", 64'(start_log[7]), 64'd2);
      c = 0;
      while (!to_err && c < 40) begin
         tick();
         c++;
      end
      chk("t5_to_lat", 64'(c), 64'd17);
      chk("t5_pend", 64'(pending), 64'h8);
      chk("t5_cur", 64'(cur_idx), 64'd2);
      chk("t5_nto", 64'(nto), 64'd1);
      hold_low = 1'b0;
      tick();
      chk("t5_to_pulse", 64'(to_err), 64'd0);
      wait_starts(9, 10, "t5_next_start");
      chk("t5_next", 64'(start_log[8]), 64'd3);
      wait_done(8, 60, "t5_done_wait");

      // reset in WAIT_DONE
      load(1, 29'h123, 64'hCAFE, 32'h0A456C80);
      wait_starts(10, 10, "t6_start");
      repeat (5) tick();
      chk("t6_busy_pre", 64'(sched_busy), 64'd1);
      #2 HRESET = 1'b1;
      #1;
      chk("t6_async_ctl", 64'({startXmit, done, to_err, ld_err, sched_busy, pending,
                               cur_idx, format, frameType, datalen}), 64'd0);
      chk("t6_async_id", 64'(id), 64'd0);
      chk("t6_async_data", xmitdata, 64'd0);
      chk("t6_async_q", 64'({quantaDiv, propQuanta, seg1Quanta}), 64'd0);
      tick();
      tick();
      HRESET = 1'b0;
      repeat (30) tick();
      chk("t6_no_done", 64'(ndone), 64'd8);
      chk("t6_pend", 64'(pending), 64'd0);
      chk("t6_idle", 64'(sched_busy), 64'd0);
      chk("t6_no_restart", 64'(start_log.size()), 64'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
